queue_reader: RTL and testbench
===============================

# queue_reader

Read-side controller for the `queue_non_fsm` FIFO. On a `start` command it pops a programmed number of words from the queue, one at a time. Each word is presented downstream on a valid/ready handshake. It sits between the queue's `stack_empty`/`data_out`/`read_from_stack` pins and any consumer, so that no consumer has to generate pop strobes itself.

## Interface
- `word_length`, 8: width of a queue word.
- `count_width`, 5: width of `burst_len` and `words_left`. Maximum burst is 2^count_width−1.
- `timeout_cycles`, 16: consecutive empty cycles before a burst aborts. Used only with `QUEUE_READER_TIMEOUT_EN`.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state.
- `start`  in  1  begin a burst; sampled only in IDLE.
- `burst_len`  in  count_width  words to pop; latched with `start`.
- `stack_empty`  in  1  queue empty flag.
- `queue_data`  in  word_length  queue `data_out`.
- `read_from_stack`  out  1  pop strobe to the queue.
- `out_data`  out  word_length  word presented downstream.
- `out_valid`  out  1  `out_data` is valid.
- `out_ready`  in  1  downstream accepts.
- `busy`  out  1  burst in progress.
- `done`  out  1  one-cycle pulse when a burst ends.
- `words_left`  out  count_width  words still to deliver.
- `timed_out`  out  1  last burst ended by timeout.

## Operation
- **States:** IDLE, REQ, WAIT, HOLD.
- **IDLE:** `busy`=0.
  - `start`=1 with `burst_len`≠0 → latch `words_left`=`burst_len`, clear `timed_out`, go to REQ.
  - `start`=1 with `burst_len`=0 → pulse `done` next cycle, stay in IDLE.
- **REQ:** `read_from_stack` = !`stack_empty`. This is combinational from state and `stack_empty`, and is high in no other state.
  - If `stack_empty`=0 → go to WAIT.
  - Otherwise stay in REQ.
- **WAIT:** the queue presents the popped word on `queue_data` during this cycle. Register it into `out_data`, set `out_valid`=1, go to HOLD.
- **HOLD:** `out_valid`=1.
  - `out_data` is frozen until `out_valid`&&`out_ready`.
  - On that handshake: `words_left` decrements and `out_valid`→0.
  - If the new `words_left`=0 → go to IDLE, `done`=1 for one cycle, `busy`=0.
  - Otherwise go to REQ.
- `start` is ignored outside IDLE.
- `busy`=1 in REQ, WAIT and HOLD.
- Exactly one pop per delivered word. The block never pops while a word is held.
- `words_left` is unsigned and never wraps. It decrements only on a handshake.

## Timing
- **Reset values:** `read_from_stack`=0, `out_data`=0, `out_valid`=0, `busy`=0, `done`=0, `words_left`=0, `timed_out`=0, state=IDLE.
- **Latency:**
  - `start` sampled at edge 0 → REQ after edge 0.
  - With a non-empty queue, `read_from_stack` is high in cycle 0–1 and the pop happens at edge 1.
  - `out_valid` goes high after edge 2.
- **Throughput:** with `out_ready` held high, the block delivers one word per 3 cycles.
- **Reset mid-burst:** returns to IDLE immediately with the reset values above. A word popped but not yet accepted downstream is discarded.
- **Empty during a burst:** the block waits in REQ indefinitely unless the timeout is compiled in.

## Configuration
- **`QUEUE_READER_TIMEOUT_EN` defined:**
  - A counter increments on each REQ cycle with `stack_empty`=1 and clears on a pop or on leaving REQ.
  - When the count reaches `timeout_cycles`, the block goes to IDLE at that edge, sets `timed_out`=1 and pulses `done`.
  - `words_left` keeps the undelivered count until the next accepted `start`.
- **Not defined:** no counter is built, `timed_out` is tied to 0, and REQ waits forever.

## Test plan
- **Reset:** assert `reset` mid-cycle with no clock edge → every output takes its reset value immediately. Repeat during HOLD → IDLE, `out_valid`=0, `words_left`=0.
- **Normal burst:** queue preloaded with 1, 10, 20; `start` with `burst_len`=3; `out_ready`=1 → `out_data` reads 1, 10, 20 on three handshakes spaced 3 cycles apart, with exactly three `read_from_stack` pulses. `words_left` steps 3→2→1→0, then `done` pulses once and `busy` falls.
- **Backpressure:** word 42 in HOLD with `out_ready`=0 for 5 cycles → `out_data`=42 stable, `out_valid`=1, no `read_from_stack`. Raise `out_ready` → one handshake.
- **Empty stall:** queue holds only 30; `burst_len`=2 → 30 is delivered, then `read_from_stack` stays 0 while empty. Write 25 after 8 cycles → pop within 1 cycle, 25 delivered, `done` pulses.
- **Corner commands:** `burst_len`=0 → `done` pulse, no pop, `busy`=0. `start` while busy → ignored and `words_left` unchanged.
- **Timeout (macro on):** empty queue, `burst_len`=4 → after 16 REQ cycles, `timed_out`=1, `done` pulses, `words_left`=4. With the macro off, the block is still in REQ after 100 cycles and `timed_out`=0.

Source files
------------

// File: rtl/queue_reader.sv
// Read-side controller for a FIFO: pops a programmed burst of words and presents each on a valid/ready port.
// Optional abort-on-empty timeout is compiled in with QUEUE_READER_TIMEOUT_EN.
`timescale 1ns/1ps
module queue_reader #(
  parameter int WORD_LENGTH = 8,
  parameter int COUNT_WIDTH = 5
`ifdef QUEUE_READER_TIMEOUT_EN
  ,
  parameter int TIMEOUT_CYCLES = 16
`endif
) (
  input  logic                   clk_i,
  input  logic                   reset_i,
  input  logic                   start_i,
  input  logic [COUNT_WIDTH-1:0] burst_len_i,
  input  logic                   stack_empty_i,
  input  logic [WORD_LENGTH-1:0] queue_data_i,
  output logic                   read_from_stack_o,
  output logic [WORD_LENGTH-1:0] out_data_o,
  output logic                   out_valid_o,
  input  logic                   out_ready_i,
  output logic                   busy_o,
  output logic                   done_o,
  output logic [COUNT_WIDTH-1:0] words_left_o,
  output logic                   timed_out_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_HOLD = 2'd3
  } state_e;

  state_e                   state_q, state_d;
  logic [WORD_LENGTH-1:0]   out_data_q, out_data_d;
  logic                     out_valid_q, out_valid_d;
  logic                     busy_q, busy_d;
  logic                     done_q, done_d;
  logic [COUNT_WIDTH-1:0]   words_left_q, words_left_d;

`ifdef QUEUE_READER_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TMO_W-1:0]         tmo_cnt_q, tmo_cnt_d;
  logic                     timed_out_q, timed_out_d;
`endif

  // The pop strobe must reach the queue in the same cycle the empty flag drops.
  assign read_from_stack_o = (state_q == S_REQ) && !stack_empty_i;

  // Next-state and next-output computation for the burst sequencer.
  always_comb begin
    state_d      = state_q;
    out_data_d   = out_data_q;
    out_valid_d  = out_valid_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    words_left_d = words_left_q;
`ifdef QUEUE_READER_TIMEOUT_EN
    tmo_cnt_d    = '0;
    timed_out_d  = timed_out_q;
`endif
    case (state_q)
      S_IDLE: begin
        busy_d      = 1'b0;
        out_valid_d = 1'b0;
        if (start_i) begin
          if (burst_len_i != '0) begin
            words_left_d = burst_len_i;
            busy_d       = 1'b1;
            state_d      = S_REQ;
`ifdef QUEUE_READER_TIMEOUT_EN
            timed_out_d  = 1'b0;
`endif
          end else begin
            done_d = 1'b1;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_REQ: begin
        if (!stack_empty_i) begin
          state_d = S_WAIT;
        end else begin
`ifdef QUEUE_READER_TIMEOUT_EN
          if (tmo_cnt_q == TMO_W'(TIMEOUT_CYCLES - 1)) begin
            state_d     = S_IDLE;
            busy_d      = 1'b0;
            done_d      = 1'b1;
            timed_out_d = 1'b1;
          end else begin
            tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
          end
`else
          state_d = S_REQ;
`endif
        end
      end
      S_WAIT: begin
        // The queue drives the popped word during this cycle only.
        out_data_d  = queue_data_i;
        out_valid_d = 1'b1;
        state_d     = S_HOLD;
      end
      S_HOLD: begin
        if (out_ready_i) begin
          out_valid_d = 1'b0;
          if (words_left_q != '0) begin
            words_left_d = words_left_q - COUNT_WIDTH'(1);
          end else begin
            words_left_d = words_left_q;
          end
          if (words_left_q <= COUNT_WIDTH'(1)) begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            state_d = S_REQ;
          end
        end else begin
          state_d = S_HOLD;
        end
      end
      default: begin
        state_d     = S_IDLE;
        busy_d      = 1'b0;
        out_valid_d = 1'b0;
      end
    endcase
  end

  // State and registered-output update.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q      <= S_IDLE;
      out_data_q   <= '0;
      out_valid_q  <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      words_left_q <= '0;
`ifdef QUEUE_READER_TIMEOUT_EN
      tmo_cnt_q    <= '0;
      timed_out_q  <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      out_data_q   <= out_data_d;
      out_valid_q  <= out_valid_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      words_left_q <= words_left_d;
`ifdef QUEUE_READER_TIMEOUT_EN
      tmo_cnt_q    <= tmo_cnt_d;
      timed_out_q  <= timed_out_d;
`endif
    end
  end

  assign out_data_o   = out_data_q;
  assign out_valid_o  = out_valid_q;
  assign busy_o       = busy_q;
  assign done_o       = done_q;
  assign words_left_o = words_left_q;
`ifdef QUEUE_READER_TIMEOUT_EN
  assign timed_out_o  = timed_out_q;
`else
  assign timed_out_o  = 1'b0;
`endif

endmodule

// File: tb/tb_queue_reader.sv
// Scoreboard bench for queue_reader: a FIFO model feeds the DUT, a monitor checks delivered words and burst bookkeeping.
`timescale 1ns/1ps
module tb_queue_reader;
  localparam int WL = 8;
  localparam int CW = 5;

  logic          clk = 1'b0;
  logic          reset_i, start_i, stack_empty_i, out_ready_i;
  logic [CW-1:0] burst_len_i;
  logic [WL-1:0] queue_data_i;
  logic          read_from_stack_o, out_valid_o, busy_o, done_o, timed_out_o;
  logic [WL-1:0] out_data_o;
  logic [CW-1:0] words_left_o;

  queue_reader dut (
    .clk_i(clk), .reset_i(reset_i), .start_i(start_i), .burst_len_i(burst_len_i),
    .stack_empty_i(stack_empty_i), .queue_data_i(queue_data_i),
    .read_from_stack_o(read_from_stack_o), .out_data_o(out_data_o), .out_valid_o(out_valid_o),
    .out_ready_i(out_ready_i), .busy_o(busy_o), .done_o(done_o),
    .words_left_o(words_left_o), .timed_out_o(timed_out_o)
  );

  always #5 clk = ~clk;

  int tests = 0, fails = 0;
  logic [WL-1:0] fifo[$];
  logic [WL-1:0] exp_q[$];
  int pop_cnt = 0, hs_cnt = 0, cyc = 0, last_hs_cyc = -1;
  int mdl_left = 0;
  bit mdl_busy = 0, exp_done = 0, hs_pend = 0, mon_en = 0, rand_ready = 0, spacing_chk = 0;
  bit prev_valid = 0, prev_ready = 0;
  logic [WL-1:0] prev_data = '0;

  task automatic chk(input string nm, input int act, input int exp_v);
    tests++;
    if (act != exp_v) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d @%0t", nm, act, exp_v, $time);
    end
  endtask

  always @(posedge clk) cyc++;

  // Queue model: a pop registers the head word onto queue_data for the following cycle.
  always @(posedge clk) begin
    if (read_from_stack_o && fifo.size() != 0) begin
      queue_data_i  <= fifo.pop_front();
      stack_empty_i <= (fifo.size() == 0);
      pop_cnt++;
    end
  end

  always @(posedge clk) begin
    if (rand_ready) begin
      #1 out_ready_i = ($urandom_range(0, 3) != 0);
    end
  end

  // Monitor: applies last cycle's handshake to the model, then checks outputs.
  always @(negedge clk) begin
    if (mon_en) begin
      if (hs_pend) begin
        hs_pend = 0;
        mdl_left--;
        if (mdl_left == 0) begin
          exp_done = 1;
          mdl_busy = 0;
        end
      end
      chk("words_left", int'(words_left_o), mdl_left);
      chk("done", int'(done_o), int'(exp_done));
      exp_done = 0;
      chk("busy", int'(busy_o), int'(mdl_busy));
      chk("timed_out", int'(timed_out_o), 0);
      chk("pop_while_held", int'(read_from_stack_o & out_valid_o), 0);
      chk("pop_when_empty", int'(read_from_stack_o & stack_empty_i), 0);
      if (prev_valid && !prev_ready) begin
        chk("hold_valid", int'(out_valid_o), 1);
        chk("hold_data", int'(out_data_o), int'(prev_data));
      end
      if (out_valid_o && out_ready_i) begin
        hs_cnt++;
        hs_pend = 1;
        chk("scoreboard_has_word", int'(exp_q.size() != 0), 1);
        if (exp_q.size() != 0) chk("out_data", int'(out_data_o), int'(exp_q.pop_front()));
        if (spacing_chk && last_hs_cyc >= 0) chk("handshake_spacing", cyc - last_hs_cyc, 3);
        last_hs_cyc = cyc;
      end
      prev_valid = out_valid_o;
      prev_ready = out_ready_i;
      prev_data  = out_data_o;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push_word(input int w);
    fifo.push_back(WL'(w));
    exp_q.push_back(WL'(w));
    stack_empty_i = 1'b0;
  endtask

  task automatic do_reset();
    mon_en = 0;
    #3 reset_i = 1'b1;
    #1;
    chk("rst_read", int'(read_from_stack_o), 0);
    chk("rst_out_data", int'(out_data_o), 0);
    chk("rst_out_valid", int'(out_valid_o), 0);
    chk("rst_busy", int'(busy_o), 0);
    chk("rst_done", int'(done_o), 0);
    chk("rst_words_left", int'(words_left_o), 0);
    chk("rst_timed_out", int'(timed_out_o), 0);
    fifo.delete();
    exp_q.delete();
    stack_empty_i = 1'b1;
    queue_data_i = '0;
    mdl_left = 0; mdl_busy = 0; exp_done = 0; hs_pend = 0;
    pop_cnt = 0; hs_cnt = 0; prev_valid = 0; prev_ready = 0;
    @(posedge clk);
    #3 reset_i = 1'b0;
    tick(1);
    mon_en = 1;
  endtask

  task automatic do_start(input int n);
    start_i = 1'b1;
    burst_len_i = CW'(n);
    @(posedge clk);
    if (n > 0) begin
      mdl_left = n;
      mdl_busy = 1;
    end else begin
      exp_done = 1;
    end
    #1 start_i = 1'b0;
    burst_len_i = CW'($urandom_range(0, 31));
  endtask

  task automatic wait_idle(input int budget);
    int k = 0;
    while (mdl_busy && k < budget) begin
      tick(1);
      k++;
    end
    chk("burst_finished", int'(mdl_busy), 0);
    tick(1);
    chk("pops_eq_words", pop_cnt, hs_cnt);
    chk("idle_no_valid", int'(out_valid_o), 0);
    if (mdl_busy) do_reset();
  endtask

  task automatic wait_valid(input int budget);
    int k = 0;
    while (!out_valid_o && k < budget) begin
      tick(1);
      k++;
    end
    chk("valid_seen", int'(out_valid_o), 1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, time %0t required under 1ms", $time);
    fails++;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $fatal(1, "watchdog");
  end

  initial begin
    int n, pre, p0;
    reset_i = 1'b1; start_i = 1'b0; burst_len_i = '0; stack_empty_i = 1'b1;
    out_ready_i = 1'b0; queue_data_i = '0;
    tick(1);
    do_reset();

    // Normal burst, one word every three cycles.
    push_word(1); push_word(10); push_word(20);
    out_ready_i = 1'b1;
    last_hs_cyc = -1;
    spacing_chk = 1;
    p0 = hs_cnt;
    do_start(3);
    wait_idle(50);
    spacing_chk = 0;
    chk("normal_three_words", hs_cnt - p0, 3);

    // Backpressure in HOLD.
    out_ready_i = 1'b0;
    push_word(42);
    do_start(1);
    wait_valid(10);
    p0 = pop_cnt;
    tick(5);
    chk("bp_no_pop", pop_cnt, p0);
    chk("bp_data", int'(out_data_o), 42);
    out_ready_i = 1'b1;
    wait_idle(20);

    // Reset while a word is held.
    out_ready_i = 1'b0;
    push_word(7); push_word(8);
    do_start(2);
    wait_valid(10);
    do_reset();

    // Empty stall, then a late write.
    out_ready_i = 1'b1;
    push_word(30);
    do_start(2);
    for (int k = 0; k < 20 && mdl_left != 1; k++) tick(1);
    tick(8);
    chk("stall_no_pop", pop_cnt, 1);
    push_word(25);
    tick(1);
    chk("pop_after_write", pop_cnt, 2);
    wait_idle(20);

    // Zero-length burst and start while busy.
    p0 = pop_cnt;
    do_start(0);
    tick(2);
    chk("zero_len_no_pop", pop_cnt, p0);
    out_ready_i = 1'b0;
    push_word(5); push_word(6); push_word(7);
    do_start(3);
    tick(2);
    start_i = 1'b1; burst_len_i = CW'(9);
    tick(1);
    start_i = 1'b0;
    tick(2);
    out_ready_i = 1'b1;
    wait_idle(40);

    // Empty queue for a long time: abort with timeout, or wait forever without it.
    do_start(4);
    mon_en = 0;
`ifdef QUEUE_READER_TIMEOUT_EN
    tick(15);
    chk("tmo_not_yet", int'(timed_out_o), 0);
    tick(1);
    chk("tmo_flag", int'(timed_out_o), 1);
    chk("tmo_done", int'(done_o), 1);
    chk("tmo_words_left", int'(words_left_o), 4);
    chk("tmo_busy", int'(busy_o), 0);
    tick(1);
    chk("tmo_done_pulse", int'(done_o), 0);
`else
    tick(100);
    chk("stuck_busy", int'(busy_o), 1);
    chk("stuck_timed_out", int'(timed_out_o), 0);
    chk("stuck_words_left", int'(words_left_o), 4);
    chk("stuck_no_pop", int'(read_from_stack_o), 0);
`endif
    do_reset();

    // Randomized bursts with random backpressure and late queue writes.
    rand_ready = 1;
    for (int it = 0; it < 25; it++) begin
      n = (it == 0) ? 31 : int'($urandom_range(0, 10));
      pre = int'($urandom_range(0, n));
      for (int j = 0; j < pre; j++) push_word(int'($urandom_range(0, 255)));
      do_start(n);
      tick(int'($urandom_range(0, 6)));
      for (int j = pre; j < n; j++) push_word(int'($urandom_range(0, 255)));
      wait_idle(n * 40 + 50);
    end
    rand_ready = 0;
    tick(2);
    chk("scoreboard_drained", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
